// File: rtl/piece_move_controller.sv
// Button debounce, gravity timer and piece movement FSM feeding the VGA overlay.
// Shadow position/colour update freely; the visible outputs reload only on iFrameStart.
//
// state   | meaning
// RUN     | piece falls under gravity, accepts move/drop/pause presses
// PAUSED  | gravity counter frozen, move presses discarded
// LANDED  | one-cycle respawn: oLanded high, position reset, colour advanced
module piece_move_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int GRAVITY_CYCLES  = 12500000,
  parameter int STEP            = 32,
  parameter int X_INIT          = 96,
  parameter int X_MAX           = 192,
  parameter int Y_MAX           = 320
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iLeft,
  input  logic       iRight,
  input  logic       iDown,
  input  logic       iPause,
  input  logic       iFrameStart,
  output logic [9:0] oXRedCounter,
  output logic [9:0] oYRedCounter,
  output logic [2:0] oColorCuadro,
  output logic       oLanded
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int GR_W = $clog2(GRAVITY_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GR_W-1:0] GR_LAST  = GR_W'(GRAVITY_CYCLES - 1);
  localparam logic [9:0]      STEP_V   = 10'(STEP);
  localparam logic [9:0]      X_INIT_V = 10'(X_INIT);
  localparam logic [9:0]      X_MAX_V  = 10'(X_MAX);
  localparam logic [9:0]      Y_MAX_V  = 10'(Y_MAX);

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_PAUSE = 3;

  typedef enum logic [1:0] {S_RUN, S_PAUSED, S_LANDED} state_t;

  state_t state, state_nxt;

  logic [3:0]      btn_raw, sync_a, sync_b, db_lvl, press;
  logic [DB_W-1:0] db_cnt [4];

  logic [9:0]      shadow_x, shadow_y, x_nxt, y_nxt;
  logic [1:0]      col_idx, col_nxt;
  logic [GR_W-1:0] grav_cnt, grav_nxt;
  logic            drop_req, land_pulse;

  function automatic logic [2:0] colour_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b100;
      2'd1:    return 3'b010;
      2'd2:    return 3'b001;
      default: return 3'b110;
    endcase
  endfunction

  assign btn_raw = {iPause, iDown, iRight, iLeft};

  // Level must disagree with the accepted level for DEBOUNCE_CYCLES clocks to flip it
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_a <= '0;
      sync_b <= '0;
      db_lvl <= '0;
      press  <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (sync_b[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync_b[i];
          db_cnt[i] <= '0;
          press[i]  <= sync_b[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign drop_req = press[BTN_DOWN] | (grav_cnt == GR_LAST);

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (press[BTN_PAUSE])                  state_nxt = S_PAUSED;
        else if (drop_req && shadow_y == Y_MAX_V) state_nxt = S_LANDED;
      end
      S_PAUSED: if (press[BTN_PAUSE]) state_nxt = S_RUN;
      default:  state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    x_nxt      = shadow_x;
    y_nxt      = shadow_y;
    col_nxt    = col_idx;
    grav_nxt   = grav_cnt;
    land_pulse = 1'b0;
    case (state)
      S_RUN: begin
        // The pause press cycle itself behaves like PAUSED: nothing moves, gravity holds
        if (!press[BTN_PAUSE]) begin
          if (press[BTN_LEFT] && !press[BTN_RIGHT] && shadow_x >= STEP_V)
            x_nxt = shadow_x - STEP_V;
          else if (press[BTN_RIGHT] && !press[BTN_LEFT] && shadow_x + STEP_V <= X_MAX_V)
            x_nxt = shadow_x + STEP_V;
          grav_nxt = drop_req ? '0 : grav_cnt + 1'b1;
          if (drop_req && shadow_y + STEP_V <= Y_MAX_V)
            y_nxt = shadow_y + STEP_V;
        end
      end
      S_LANDED: begin
        x_nxt      = X_INIT_V;
        y_nxt      = '0;
        grav_nxt   = '0;
        col_nxt    = col_idx + 2'd1;
        land_pulse = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      shadow_x     <= X_INIT_V;
      shadow_y     <= '0;
      col_idx      <= '0;
      grav_cnt     <= '0;
      oXRedCounter <= X_INIT_V;
      oYRedCounter <= '0;
      oColorCuadro <= 3'b100;
    end else begin
      shadow_x <= x_nxt;
      shadow_y <= y_nxt;
      col_idx  <= col_nxt;
      grav_cnt <= grav_nxt;
      if (iFrameStart) begin
        oXRedCounter <= shadow_x;
        oYRedCounter <= shadow_y;
        oColorCuadro <= colour_of(col_idx);
      end
    end
  end

  // Masked by Reset so a reset landing in the LANDED cycle never shows a pulse
  assign oLanded = land_pulse & ~Reset;

endmodule
